// File: rtl/mcu_packet_parser.sv
`default_nettype none
// ============================================================================
//  Module      : mcu_packet_parser
//  Description : Byte-level packet parser for the MCU-side SPI byte stream.
//                Decodes a header byte, then either assembles an interest
//                prefix or forwards data payload bytes with an index.
//                Truncated and over-length frames raise frame_error.
//  Ports       : clk, rst_n            - clock, async active-low reset
//                frame_active          - frame selected (synchronized ss)
//                byte_valid, byte_in   - received byte strobe and value
//                interest_valid/len/prefix - completed interest packet
//                data_valid/byte/index/last - forwarded payload bytes
//                frame_error           - truncated or over-length frame
//                busy                  - parser not idle
//  Revision    : 1.0 - initial release
// ============================================================================
module mcu_packet_parser #(
    parameter int PREFIX_BYTES = 8,
    parameter int DATA_BYTES   = 256
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      frame_active,
    input  logic                      byte_valid,
    input  logic [7:0]                byte_in,
    output logic                      interest_valid,
    output logic [5:0]                interest_len,
    output logic [8*PREFIX_BYTES-1:0] interest_prefix,
    output logic                      data_valid,
    output logic [7:0]                data_byte,
    output logic [7:0]                data_index,
    output logic                      data_last,
    output logic                      frame_error,
    output logic                      busy
);

    localparam int c_PFX_W = 8 * PREFIX_BYTES;
    localparam int c_CNT_W = $clog2(DATA_BYTES);
    localparam logic [c_CNT_W-1:0] c_PFX_LAST  = c_CNT_W'(PREFIX_BYTES - 1);
    localparam logic [c_CNT_W-1:0] c_DATA_LAST = c_CNT_W'(DATA_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HEADER = 3'd1,
        S_PREFIX = 3'd2,
        S_DATA   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t               r_state,  w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt,    w_cnt_nxt;
    logic [c_PFX_W-1:0]   r_shift,  w_shift_nxt;
    logic [5:0]           r_len,    w_len_nxt;
    logic                 r_ovr,    w_ovr_nxt;
    logic                 r_fa_q;

    logic                 w_iv;
    logic [5:0]           w_ilen;
    logic [c_PFX_W-1:0]   w_ipfx;
    logic                 w_dv;
    logic [7:0]           w_dbyte;
    logic [7:0]           w_didx;
    logic                 w_dlast;
    logic                 w_ferr;

    logic                 w_byte;
    logic [c_PFX_W-1:0]   w_pfx_shifted;

    // A byte is accepted while the frame is active, and also in the single
    // cycle where frame_active has just dropped: a byte that lands together
    // with the frame end is processed before the end-of-frame handling.
    assign w_byte        = byte_valid & (frame_active | r_fa_q);
    assign w_pfx_shifted = {r_shift[c_PFX_W-9:0], byte_in};

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shift_nxt = r_shift;
        w_len_nxt   = r_len;
        w_ovr_nxt   = r_ovr;
        w_iv        = 1'b0;
        w_ilen      = interest_len;
        w_ipfx      = interest_prefix;
        w_dv        = 1'b0;
        w_dbyte     = data_byte;
        w_didx      = data_index;
        w_dlast     = 1'b0;
        w_ferr      = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_ovr_nxt = 1'b0;
                if (frame_active) begin
                    w_state_nxt = S_HEADER;
                end
            end

            S_HEADER: begin
                if (w_byte) begin
                    w_len_nxt = byte_in[5:0];
                    w_cnt_nxt = '0;
                    if (byte_in[6]) begin
                        w_shift_nxt = '0;
                        w_state_nxt = S_PREFIX;
                    end else begin
                        w_state_nxt = S_DATA;
                    end
                    // Header arrived on the closing edge: packet cannot complete.
                    if (!frame_active) begin
                        w_ferr      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end else if (!frame_active) begin
                    // Empty frame: nothing was started, so nothing to report.
                    w_state_nxt = S_IDLE;
                end
            end

            S_PREFIX: begin
                if (w_byte) begin
                    w_shift_nxt = w_pfx_shifted;
                    w_cnt_nxt   = r_cnt + 1'b1;
                    if (r_cnt == c_PFX_LAST) begin
                        w_iv        = 1'b1;
                        w_ilen      = r_len;
                        w_ipfx      = w_pfx_shifted;
                        w_state_nxt = S_DONE;
                    end else if (!frame_active) begin
                        w_ferr      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end else if (!frame_active) begin
                    w_ferr      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end

            S_DATA: begin
                if (w_byte) begin
                    w_dv      = 1'b1;
                    w_dbyte   = byte_in;
                    w_didx    = 8'(r_cnt);
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (r_cnt == c_DATA_LAST) begin
                        w_dlast     = 1'b1;
                        w_state_nxt = S_DONE;
                    end else if (!frame_active) begin
                        w_ferr      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end else if (!frame_active) begin
                    w_ferr      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end

            S_DONE: begin
                // Bytes beyond the packet are swallowed and remembered.
                w_ovr_nxt = r_ovr | w_byte;
                if (!frame_active) begin
                    w_ferr      = w_ovr_nxt;
                    w_ovr_nxt   = 1'b0;
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= S_IDLE;
            r_cnt           <= '0;
            r_shift         <= '0;
            r_len           <= '0;
            r_ovr           <= 1'b0;
            r_fa_q          <= 1'b0;
            interest_valid  <= 1'b0;
            interest_len    <= '0;
            interest_prefix <= '0;
            data_valid      <= 1'b0;
            data_byte       <= '0;
            data_index      <= '0;
            data_last       <= 1'b0;
            frame_error     <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_cnt           <= w_cnt_nxt;
            r_shift         <= w_shift_nxt;
            r_len           <= w_len_nxt;
            r_ovr           <= w_ovr_nxt;
            r_fa_q          <= frame_active;
            interest_valid  <= w_iv;
            interest_len    <= w_ilen;
            interest_prefix <= w_ipfx;
            data_valid      <= w_dv;
            data_byte       <= w_dbyte;
            data_index      <= w_didx;
            data_last       <= w_dlast;
            frame_error     <= w_ferr;
        end
    end

    assign busy = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mcu_packet_parser.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mcu_packet_parser
//  Description : Scoreboard bench for mcu_packet_parser. Stimulus pushes the
//                expected output events (with the cycle they must appear in)
//                into a queue; a negedge monitor pops and compares every
//                interest_valid / data_valid / frame_error pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mcu_packet_parser;

    logic        clk;
    logic        rst_n;
    logic        frame_active;
    logic        byte_valid;
    logic [7:0]  byte_in;
    logic        interest_valid;
    logic [5:0]  interest_len;
    logic [63:0] interest_prefix;
    logic        data_valid;
    logic [7:0]  data_byte;
    logic [7:0]  data_index;
    logic        data_last;
    logic        frame_error;
    logic        busy;

    mcu_packet_parser #(
        .PREFIX_BYTES (8),
        .DATA_BYTES   (256)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .frame_active    (frame_active),
        .byte_valid      (byte_valid),
        .byte_in         (byte_in),
        .interest_valid  (interest_valid),
        .interest_len    (interest_len),
        .interest_prefix (interest_prefix),
        .data_valid      (data_valid),
        .data_byte       (data_byte),
        .data_index      (data_index),
        .data_last       (data_last),
        .frame_error     (frame_error),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    localparam int c_K_INT = 1;
    localparam int c_K_DAT = 2;
    localparam int c_K_ERR = 3;

    typedef struct {
        int          kind;
        int          cyc;
        logic [5:0]  len;
        logic [63:0] pfx;
        logic [7:0]  b;
        logic [7:0]  idx;
        logic        last;
    } exp_t;

    exp_t q[$];

    function automatic logic [127:0] pack(input exp_t e);
        return {9'b0, 8'(e.kind), 24'(e.cyc), e.len, e.pfx, e.b, e.idx, e.last};
    endfunction

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic exp_t mk(input int k, input int c);
        exp_t e;
        e.kind = k; e.cyc = c; e.len = '0; e.pfx = '0;
        e.b = '0; e.idx = '0; e.last = 1'b0;
        return e;
    endfunction

    // Expectations are pushed just before the causing input is driven, so the
    // pulse must appear one clock later than the current cycle.
    task automatic push_int(input logic [5:0] l, input logic [63:0] p);
        exp_t e;
        e = mk(c_K_INT, cyc + 1);
        e.len = l; e.pfx = p;
        q.push_back(e);
    endtask

    task automatic push_dat(input logic [7:0] b, input logic [7:0] idx, input logic last);
        exp_t e;
        e = mk(c_K_DAT, cyc + 1);
        e.b = b; e.idx = idx; e.last = last;
        q.push_back(e);
    endtask

    task automatic push_err();
        q.push_back(mk(c_K_ERR, cyc + 1));
    endtask

    task automatic take(input string nm, input exp_t a);
        exp_t e;
        if (q.size() == 0) begin
            check({"unexpected_", nm}, pack(a), '0);
        end else begin
            e = q.pop_front();
            check(nm, pack(a), pack(e));
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        exp_t a;
        if (rst_n) begin
            if (interest_valid) begin
                a = mk(c_K_INT, cyc);
                a.len = interest_len; a.pfx = interest_prefix;
                take("interest", a);
            end
            if (data_valid) begin
                a = mk(c_K_DAT, cyc);
                a.b = data_byte; a.idx = data_index; a.last = data_last;
                take("data", a);
            end
            if (frame_error) begin
                take("frame_error", mk(c_K_ERR, cyc));
            end
            if (data_last && !data_valid) begin
                check("data_last_without_valid", 128'(data_last), 128'(0));
            end
        end
    end

    // All drive helpers start and end at 1 time unit after a rising edge.
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_in    = b;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_interest_valid"},  128'(interest_valid),  '0);
        check({tag, "_interest_len"},    128'(interest_len),    '0);
        check({tag, "_interest_prefix"}, 128'(interest_prefix), '0);
        check({tag, "_data_valid"},      128'(data_valid),      '0);
        check({tag, "_data_byte"},       128'(data_byte),       '0);
        check({tag, "_data_index"},      128'(data_index),      '0);
        check({tag, "_data_last"},       128'(data_last),       '0);
        check({tag, "_frame_error"},     128'(frame_error),     '0);
        check({tag, "_busy"},            128'(busy),            '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        frame_active = 1'b0;
        byte_valid   = 1'b0;
        byte_in      = 8'h00;
        idle(3);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        idle(2);
        check("busy_after_reset", 128'(busy), '0);

        // Interest: header 0x48, prefix 01..08
        frame_active = 1'b1;
        idle(2);
        check("busy_in_frame", 128'(busy), 128'(1));
        send(8'h48);
        for (int i = 1; i <= 8; i++) begin
            if (i == 8) push_int(6'd8, 64'h0102030405060708);
            send(8'(i));
        end
        idle(2);
        frame_active = 1'b0;
        idle(3);
        check("drain_interest", 128'(q.size()), '0);

        // Data: header 0x00, 256 back-to-back bytes
        frame_active = 1'b1;
        idle(2);
        send(8'h00);
        for (int i = 0; i < 256; i++) begin
            push_dat(8'(i), 8'(i), i == 255);
            send(8'(i));
        end
        idle(2);
        frame_active = 1'b0;
        idle(3);
        check("drain_data", 128'(q.size()), '0);

        // Truncation: header 0x7F plus three prefix bytes
        frame_active = 1'b1;
        idle(2);
        send(8'h7F);
        send(8'hAA);
        send(8'hBB);
        send(8'hCC);
        push_err();
        frame_active = 1'b0;
        idle(3);
        check("drain_trunc", 128'(q.size()), '0);
        check("trunc_prefix_held", 128'(interest_prefix), 128'(64'h0102030405060708));
        check("trunc_len_held",    128'(interest_len),    128'(8));

        // Overrun: complete interest (len 5), two extra bytes
        frame_active = 1'b1;
        idle(2);
        send(8'hC5);
        for (int i = 1; i <= 8; i++) begin
            if (i == 8) push_int(6'd5, 64'h1122334455667788);
            send(8'(i * 8'h11));
        end
        send(8'h99);
        send(8'h9A);
        idle(2);
        push_err();
        frame_active = 1'b0;
        idle(3);
        check("drain_overrun", 128'(q.size()), '0);

        // Last prefix byte coincides with the frame end
        frame_active = 1'b1;
        idle(2);
        send(8'h43);
        for (int i = 1; i <= 7; i++) send(8'(8'hA0 + i));
        push_int(6'd3, 64'hA1A2A3A4A5A6A7A8);
        frame_active = 1'b0;
        send(8'hA8);
        idle(3);
        check("drain_boundary", 128'(q.size()), '0);
        check("boundary_idle", 128'(busy), '0);

        // Bytes with no frame selected are ignored
        idle(3);
        send(8'h48);
        send(8'h01);
        send(8'h02);
        idle(3);
        check("ignore_busy", 128'(busy), '0);
        check("ignore_prefix", 128'(interest_prefix), 128'(64'hA1A2A3A4A5A6A7A8));
        check("drain_ignore", 128'(q.size()), '0);

        // Reset in the middle of a data packet, at index 100
        frame_active = 1'b1;
        idle(2);
        send(8'h00);
        for (int i = 0; i < 100; i++) begin
            push_dat(8'(i ^ 8'h5A), 8'(i), 1'b0);
            send(8'(i ^ 8'h5A));
        end
        @(negedge clk);
        #1;
        byte_valid = 1'b1;
        byte_in    = 8'h64;
        rst_n      = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        byte_valid   = 1'b0;
        frame_active = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(2);
        check("drain_reset", 128'(q.size()), '0);

        // Next frame after reset parses from its header
        frame_active = 1'b1;
        idle(2);
        send(8'h48);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) push_int(6'd8, 64'h1011121314151617);
            send(8'(8'h10 + i));
        end
        idle(2);
        frame_active = 1'b0;
        idle(5);
        check("drain_final", 128'(q.size()), '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
